// File: rtl/uart_stim_gen.sv
// uart_stim_gen
// Parametrised UART frame generator used as a repeatable serial stimulus source.
// A run is started with a one-cycle start pulse. It then emits framed traffic
// (start, LSB-first data, optional parity, stop bits, optional idle gap) until
// frame_count frames have been sent or stop is seen at a frame boundary.
//
// Ports:
//   sys_clk      in   sole clock
//   sys_rst_n    in   asynchronous active-low reset
//   start        in   one-cycle run request, honoured only while idle
//   mode         in   payload mode latched on start (0 inc, 1 LFSR, 2 fixed, 3 alternating)
//   frame_count  in   frames per run latched on start, 0 = continuous
//   stop         in   level request to end the run at the next frame boundary
//   uart_txd     out  serial line, idle high
//   busy         out  high while a run is in progress
//   done         out  one-cycle pulse in the last cycle of the final frame
//   frame_strobe out  one-cycle pulse in the first cycle of each start bit
//   frame_data   out  payload of the frame being sent, held until the next strobe
//   frames_sent  out  completed frames in the current run
module uart_stim_gen #(
  parameter int unsigned CLKS_PER_BIT = 1736,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned IDLE_GAP     = 0,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [15:0]          frame_count,
  input  logic                 stop,
  output logic                 uart_txd,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_strobe,
  output logic [DATA_BITS-1:0] frame_data,
  output logic [15:0]          frames_sent
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(CLKS_PER_BIT - 32'd2);

  localparam logic [15:0] DATA_LAST = 16'(DATA_BITS - 32'd1);
  localparam logic [15:0] STOP_LAST = 16'(STOP_BITS - 32'd1);
  localparam logic [15:0] GAP_LAST  = (IDLE_GAP > 32'd0) ? 16'(IDLE_GAP - 32'd1) : 16'd0;
  localparam logic [15:0] ALT_INIT  = 16'h0055;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_FIX  = 2'd2;
  localparam logic [1:0] MODE_ALT  = 2'd3;

  // Even parity is the XOR of the payload; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == 32'd1);
  endfunction

  // Next payload-generator state for the given mode.
  function automatic logic [15:0] gen_advance(input logic [1:0] m, input logic [15:0] g);
    logic [15:0] r;
    case (m)
      MODE_INC:  r = g + 16'd1;
      MODE_LFSR: r = {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
      MODE_FIX:  r = g;
      MODE_ALT:  r = ~g;
      default:   r = g;
    endcase
    return r;
  endfunction

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [15:0]          bit_cnt_q, bit_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [15:0]          fcount_q, fcount_d;
  logic [15:0]          frames_sent_q, frames_sent_d;
  logic [15:0]          gen_q, gen_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] fdata_q, fdata_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 strobe_q, strobe_d;

  logic bit_last_s;
  logic bit_pen_s;
  logic last_stop_s;
  logic frame_last_s;
  logic enter_start_s;

  assign bit_last_s   = (clk_cnt_q == CNT_LAST);
  assign bit_pen_s    = (clk_cnt_q == CNT_PEN);
  assign last_stop_s  = (state_q == ST_STOP) && (bit_cnt_q == STOP_LAST);
  // The final bit-time of a frame is the last gap bit if a gap exists, else the last stop bit.
  assign frame_last_s = (IDLE_GAP > 32'd0) ? ((state_q == ST_GAP) && (bit_cnt_q == GAP_LAST))
                                           : last_stop_s;

  // Next-state logic: FSM, bit timing, payload generator and registered outputs.
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    mode_d        = mode_q;
    fcount_d      = fcount_q;
    frames_sent_d = frames_sent_q;
    gen_d         = gen_q;
    shift_d       = shift_q;
    fdata_d       = fdata_q;
    strobe_d      = 1'b0;
    done_d        = 1'b0;
    enter_start_s = 1'b0;

    if ((state_q == ST_IDLE) || bit_last_s) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Frame-end bookkeeping is done one cycle early so that frames_sent and
    // done are already registered during the last cycle of the bit.
    if (bit_pen_s && last_stop_s) begin
      frames_sent_d = frames_sent_q + 16'd1;
      gen_d         = gen_advance(mode_q, gen_q);
    end else begin
      frames_sent_d = frames_sent_q;
    end
    if (bit_pen_s && frame_last_s) begin
      done_d = stop || ((fcount_q != 16'd0) && (frames_sent_d == fcount_q));
    end else begin
      done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d        = mode;
          fcount_d      = frame_count;
          frames_sent_d = 16'd0;
          gen_d         = (mode == MODE_ALT) ? ALT_INIT : SEED;
          state_d       = ST_START;
          enter_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_last_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 16'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_last_s) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = (PARITY != 32'd0) ? ST_PAR : ST_STOP;
            bit_cnt_d = 16'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 16'd1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAR: begin
        if (bit_last_s) begin
          state_d   = ST_STOP;
          bit_cnt_d = 16'd0;
        end else begin
          state_d = ST_PAR;
        end
      end
      ST_STOP: begin
        if (bit_last_s) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 16'd0;
            if (IDLE_GAP > 32'd0) begin
              state_d = ST_GAP;
            end else if (done_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d       = ST_START;
              enter_start_s = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_GAP: begin
        if (bit_last_s) begin
          if (bit_cnt_q == GAP_LAST) begin
            bit_cnt_d = 16'd0;
            if (done_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d       = ST_START;
              enter_start_s = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new frame snapshots the generator output for both the shifter and frame_data.
    if (enter_start_s) begin
      strobe_d = 1'b1;
      fdata_d  = gen_d[DATA_BITS-1:0];
      shift_d  = gen_d[DATA_BITS-1:0];
    end else begin
      strobe_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      ST_PAR:   txd_d = parity_bit(fdata_q);
      ST_IDLE:  txd_d = 1'b1;
      ST_STOP:  txd_d = 1'b1;
      ST_GAP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line high with no done pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= 16'd0;
      mode_q        <= 2'd0;
      fcount_q      <= 16'd0;
      frames_sent_q <= 16'd0;
      gen_q         <= SEED;
      shift_q       <= '0;
      fdata_q       <= '0;
      txd_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      strobe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      mode_q        <= mode_d;
      fcount_q      <= fcount_d;
      frames_sent_q <= frames_sent_d;
      gen_q         <= gen_d;
      shift_q       <= shift_d;
      fdata_q       <= fdata_d;
      txd_q         <= txd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      strobe_q      <= strobe_d;
    end
  end

  assign uart_txd     = txd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign frame_strobe = strobe_q;
  assign frame_data   = fdata_q;
  assign frames_sent  = frames_sent_q;

endmodule

// File: tb/tb_uart_stim_gen.sv
// Testbench for uart_stim_gen. Four instances with different framing
// parameters share one clock; a payload scoreboard holds the expected data of
// each frame, and the serial line is compared bit by bit at mid-bit.
module tb_uart_stim_gen;

  localparam int CPB  = 4;
  localparam int NDUT = 4;
  localparam int          PAR_T  [NDUT] = '{0, 0, 2, 1};
  localparam int          STOP_T [NDUT] = '{1, 1, 2, 1};
  localparam int          GAP_T  [NDUT] = '{0, 0, 1, 0};
  localparam logic [15:0] SEED_T [NDUT] = '{16'h00A5, 16'h00FE, 16'h0007, 16'hACE1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s  [NDUT];
  logic [1:0]  mode_s   [NDUT];
  logic [15:0] fc_s     [NDUT];
  logic        stop_s   [NDUT];
  logic        txd_s    [NDUT];
  logic        busy_s   [NDUT];
  logic        done_s   [NDUT];
  logic        strobe_s [NDUT];
  logic [7:0]  fdata_s  [NDUT];
  logic [15:0] fsent_s  [NDUT];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_stim_gen #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .PARITY      (PAR_T[g]),
      .STOP_BITS   (STOP_T[g]),
      .IDLE_GAP    (GAP_T[g]),
      .SEED        (SEED_T[g])
    ) u_dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .start       (start_s[g]),
      .mode        (mode_s[g]),
      .frame_count (fc_s[g]),
      .stop        (stop_s[g]),
      .uart_txd    (txd_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .frame_strobe(strobe_s[g]),
      .frame_data  (fdata_s[g]),
      .frames_sent (fsent_s[g])
    );
  end

  // Reference 16-bit Fibonacci LFSR step.
  function automatic logic [15:0] lfsr_ref(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference payload sequence step for each mode.
  function automatic logic [15:0] model_next(input logic [1:0] m, input logic [15:0] g);
    case (m)
      2'd0:    return g + 16'd1;
      2'd1:    return lfsr_ref(g);
      2'd2:    return g;
      default: return ~g;
    endcase
  endfunction

  // Starts a run on instance d and checks every frame until done.
  // stop_at > 0 raises stop two bit-times into that frame number.
  task automatic run_frames(input int d, input logic [1:0] m, input logic [15:0] fc,
                            input int nexp, input int stop_at);
    int L, per, t, s_t, nst, lim, off, lastsb;
    logic [15:0] g;
    logic [15:0] fb;
    logic [7:0]  pay;
    bit got_done;
    L      = 1 + 8 + ((PAR_T[d] != 0) ? 1 : 0) + STOP_T[d] + GAP_T[d];
    per    = L * CPB;
    lastsb = (L - GAP_T[d]) * CPB - 1;
    g = (m == 2'd3) ? 16'h0055 : SEED_T[d];
    exp_q.delete();
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back(g[7:0]);
      g = model_next(m, g);
    end
    @(negedge clk);
    mode_s[d]  = m;
    fc_s[d]    = fc;
    start_s[d] = 1'b1;
    t = 0; s_t = 0; nst = 0; got_done = 1'b0; fb = 16'hFFFF;
    lim = nexp * per + 20;
    while (!got_done && t < lim) begin
      @(negedge clk);
      t++;
      start_s[d] = 1'b0;
      if (t == 1) begin
        checks++;
        if (busy_s[d] !== 1'b1 || txd_s[d] !== 1'b0 || strobe_s[d] !== 1'b1)
          begin errors++; $display("FAIL first_cycle d=%0d busy=%b txd=%b strobe=%b want 1 0 1", d, busy_s[d], txd_s[d], strobe_s[d]); end
      end
      if (t == 2) begin
        mode_s[d] = ~m;
        fc_s[d]   = 16'd1;
      end
      if (strobe_s[d] === 1'b1) begin
        checks++;
        if ((nst == 0 && t != 1) || (nst > 0 && t - s_t != per))
          begin errors++; $display("FAIL strobe_spacing d=%0d t=%0d prev=%0d want spacing %0d", d, t, s_t, per); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_frame d=%0d got %0h want none", d, fdata_s[d]);
          pay = fdata_s[d];
        end else begin
          pay = exp_q.pop_front();
          if (fdata_s[d] !== pay)
            begin errors++; $display("FAIL payload d=%0d frame %0d got %0h want %0h", d, nst, fdata_s[d], pay); end
        end
        fb = 16'hFFFF;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = pay[i];
        if (PAR_T[d] != 0) fb[9] = (^pay) ^ (PAR_T[d] == 1);
        s_t = t;
        nst++;
      end
      if (nst > 0) begin
        off = t - s_t;
        if (off % CPB == CPB / 2) begin
          checks++;
          if (txd_s[d] !== fb[off / CPB])
            begin errors++; $display("FAIL serial_bit d=%0d frame %0d bit %0d got %b want %b", d, nst, off / CPB, txd_s[d], fb[off / CPB]); end
        end
        if (off == lastsb - 1) begin
          checks++;
          if (fsent_s[d] !== 16'(nst - 1))
            begin errors++; $display("FAIL frames_sent_early d=%0d got %0d want %0d", d, fsent_s[d], nst - 1); end
        end
        if (off == lastsb) begin
          checks++;
          if (fsent_s[d] !== 16'(nst))
            begin errors++; $display("FAIL frames_sent_update d=%0d got %0d want %0d", d, fsent_s[d], nst); end
        end
        if (stop_at > 0 && nst == stop_at && off == 2 * CPB) stop_s[d] = 1'b1;
        if (nst == 2 && off == CPB) start_s[d] = 1'b1;
      end
      checks++;
      if (busy_s[d] !== 1'b1)
        begin errors++; $display("FAIL busy_in_run d=%0d t=%0d got %b want 1", d, t, busy_s[d]); end
      if (done_s[d] === 1'b1) begin
        got_done = 1'b1;
        checks++;
        if (t != nexp * per)
          begin errors++; $display("FAIL done_time d=%0d got %0d want %0d", d, t, nexp * per); end
        checks++;
        if (fsent_s[d] !== 16'(nexp) || nst != nexp || exp_q.size() != 0)
          begin errors++; $display("FAIL frame_total d=%0d sent=%0d strobes=%0d left=%0d want %0d", d, fsent_s[d], nst, exp_q.size(), nexp); end
      end
    end
    if (!got_done) begin
      errors++;
      $display("FAIL done_timeout d=%0d got no done want done by %0d", d, nexp * per);
    end else begin
      @(negedge clk);
      checks++;
      if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || txd_s[d] !== 1'b1)
        begin errors++; $display("FAIL run_end d=%0d busy=%b done=%b txd=%b want 0 0 1", d, busy_s[d], done_s[d], txd_s[d]); end
    end
    stop_s[d]  = 1'b0;
    start_s[d] = 1'b0;
    mode_s[d]  = 2'd0;
    fc_s[d]    = 16'd0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (txd_s[d] !== 1'b1 || busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 ||
          strobe_s[d] !== 1'b0 || fdata_s[d] !== 8'h00 || fsent_s[d] !== 16'd0)
        begin errors++; $display("FAIL reset_state d=%0d txd=%b busy=%b done=%b strobe=%b data=%0h sent=%0d want 1 0 0 0 0 0",
                                 d, txd_s[d], busy_s[d], done_s[d], strobe_s[d], fdata_s[d], fsent_s[d]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed();
    run_frames(0, 2'd2, 16'd1, 1, 0);
    checks++;
    if (fsent_s[0] !== 16'd1 || fdata_s[0] !== 8'hA5)
      begin errors++; $display("FAIL fixed_hold sent=%0d data=%0h want 1 a5", fsent_s[0], fdata_s[0]); end
  endtask

  task automatic test_increment();
    run_frames(1, 2'd0, 16'd3, 3, 0);
  endtask

  task automatic test_parity();
    run_frames(2, 2'd2, 16'd2, 2, 0);
    run_frames(2, 2'd0, 16'd2, 2, 0);
  endtask

  task automatic test_lfsr();
    run_frames(3, 2'd1, 16'd4, 4, 0);
  endtask

  task automatic test_alternating();
    run_frames(0, 2'd3, 16'd3, 3, 0);
  endtask

  task automatic test_continuous();
    run_frames(0, 2'd0, 16'd0, 5, 5);
  endtask

  task automatic test_back_to_back();
    int t;
    bit seen;
    exp_q.delete();
    exp_q.push_back(8'hFE);
    @(negedge clk);
    mode_s[1] = 2'd2; fc_s[1] = 16'd1; start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    checks++;
    if (strobe_s[1] !== 1'b1 || fdata_s[1] !== exp_q.pop_front())
      begin errors++; $display("FAIL b2b_first strobe=%b data=%0h want 1 fe", strobe_s[1], fdata_s[1]); end
    seen = 1'b0; t = 1;
    while (!seen && t < 100) begin
      @(negedge clk); t++;
      if (done_s[1] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || t != 40)
      begin errors++; $display("FAIL b2b_done1 seen=%b t=%0d want 1 40", seen, t); end
    start_s[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_s[1] !== 1'b0 || strobe_s[1] !== 1'b0)
      begin errors++; $display("FAIL start_with_done busy=%b strobe=%b want 0 0", busy_s[1], strobe_s[1]); end
    exp_q.push_back(8'hFE);
    @(negedge clk);
    start_s[1] = 1'b0;
    checks++;
    if (busy_s[1] !== 1'b1 || strobe_s[1] !== 1'b1 || fdata_s[1] !== exp_q.pop_front())
      begin errors++; $display("FAIL b2b_restart busy=%b strobe=%b data=%0h want 1 1 fe", busy_s[1], strobe_s[1], fdata_s[1]); end
    seen = 1'b0; t = 1;
    while (!seen && t < 100) begin
      @(negedge clk); t++;
      if (done_s[1] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || t != 40)
      begin errors++; $display("FAIL b2b_done2 seen=%b t=%0d want 1 40", seen, t); end
    @(negedge clk);
    mode_s[1] = 2'd0; fc_s[1] = 16'd0;
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    mode_s[0] = 2'd2; fc_s[0] = 16'd1; start_s[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    checks++;
    if (txd_s[0] !== 1'b0 || busy_s[0] !== 1'b1)
      begin errors++; $display("FAIL pre_reset txd=%b busy=%b want 0 1", txd_s[0], busy_s[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txd_s[0] !== 1'b1 || busy_s[0] !== 1'b0)
      begin errors++; $display("FAIL reset_async txd=%b busy=%b want 1 0", txd_s[0], busy_s[0]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      checks++;
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || txd_s[0] !== 1'b1)
        begin errors++; $display("FAIL reset_quiet i=%0d done=%b busy=%b txd=%b want 0 0 1", i, done_s[0], busy_s[0], txd_s[0]); end
    end
    run_frames(0, 2'd2, 16'd1, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 2'd0;
      fc_s[d]    = 16'd0;
      stop_s[d]  = 1'b0;
    end
    test_reset();
    test_fixed();
    test_increment();
    test_parity();
    test_lfsr();
    test_alternating();
    test_continuous();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
